// File: rtl/multicycle_control.sv
// Main control unit for the multicycle MIPS core: a Moore FSM that sequences
// fetch, decode and execute, drives every datapath control line, decodes the
// ALU operation, and flags illegal instructions and overflow traps.
module multicycle_control #(
    parameter bit OVF_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        overflow,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUSrcB,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        PCWriteCond,
    output logic        PCWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        IRWrite,
    output logic [3:0]  ALUControl,
    output logic [3:0]  state,
    output logic        illegal,
    output logic        trap
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef struct packed {
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic       pc_write_cond;
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [3:0] alu_control;
        logic       trap;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    state_t      state_q;
    state_t      state_n;
    logic        ovf_q;
    logic        ovf_n;
    ctrl_t       ctrl_q;
    ctrl_t       ctrl_out;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        funct_legal;
    logic        opcode_legal;
    logic        unused_bits;

    assign opcode      = instruction[31:26];
    assign funct       = instruction[5:0];
    assign unused_bits = ^instruction[25:6];

    // ALU decoder: funct field to 4-bit ALU operation (ADD for anything unknown).
    function automatic logic [3:0] alu_from_funct(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_ADDU: alu_from_funct = ALU_ADD;
            FN_SUB, FN_SUBU: alu_from_funct = ALU_SUB;
            FN_AND:          alu_from_funct = ALU_AND;
            FN_OR:           alu_from_funct = ALU_OR;
            FN_NOR:          alu_from_funct = ALU_NOR;
            FN_SLT:          alu_from_funct = ALU_SLT;
            default:         alu_from_funct = ALU_ADD;
        endcase
    endfunction

    // Control word for a given state; only the write-back states look at the
    // overflow flag, and only EXECUTE looks at funct.
    function automatic ctrl_t decode_state(input state_t s, input logic ovf, input logic [5:0] fn);
        ctrl_t c;
        logic  suppress;
        c = '0;
        c.alu_control = ALU_ADD;
        suppress = ovf & OVF_TRAP;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                c.iord      = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_EXECUTE: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = alu_from_funct(fn);
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = ~suppress;
                c.trap      = suppress;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_control   = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                c.reg_write = ~suppress;
                c.trap      = suppress;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b11;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    // Legality of the current instruction, used for DECODE dispatch and the illegal pulse.
    always_comb begin
        funct_legal = 1'b0;
        case (funct)
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_NOR, FN_SLT: funct_legal = 1'b1;
            default:                       funct_legal = 1'b0;
        endcase
        opcode_legal = 1'b0;
        case (opcode)
            OP_RTYPE:                          opcode_legal = funct_legal;
            OP_LW, OP_SW, OP_BEQ,
            OP_ADDI, OP_ADDIU, OP_J:           opcode_legal = 1'b1;
            default:                           opcode_legal = 1'b0;
        endcase
    end

    // Next state and next overflow flag; overflow only matters for trapping ops.
    always_comb begin
        state_n = S_FETCH;
        ovf_n   = 1'b0;
        case (state_q)
            S_FETCH:    state_n = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:      state_n = S_MEMADR;
                    OP_RTYPE:          state_n = funct_legal ? S_EXECUTE : S_FETCH;
                    OP_BEQ:            state_n = S_BRANCH;
                    OP_ADDI, OP_ADDIU: state_n = S_ADDIEX;
                    OP_J:              state_n = S_JUMP;
                    default:           state_n = S_FETCH;
                endcase
            end
            S_MEMADR:   state_n = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_n = S_MEMWB;
            S_EXECUTE: begin
                state_n = S_ALUWB;
                ovf_n   = overflow & ((funct == FN_ADD) | (funct == FN_SUB));
            end
            S_ADDIEX: begin
                state_n = S_ADDIWB;
                ovf_n   = overflow & (opcode == OP_ADDI);
            end
            default:    state_n = S_FETCH;
        endcase
    end

    // State, overflow flag and registered control word for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ovf_q   <= 1'b0;
            ctrl_q  <= decode_state(S_FETCH, 1'b0, funct);
        end else begin
            state_q <= state_n;
            ovf_q   <= ovf_n;
            ctrl_q  <= decode_state(state_n, ovf_n, funct);
        end
    end

    assign ctrl_out    = rst ? '0 : ctrl_q;
    assign PCSource    = ctrl_out.pc_source;
    assign ALUSrcB     = ctrl_out.alu_src_b;
    assign ALUSrcA     = ctrl_out.alu_src_a;
    assign RegWrite    = ctrl_out.reg_write;
    assign RegDst      = ctrl_out.reg_dst;
    assign PCWriteCond = ctrl_out.pc_write_cond;
    assign PCWrite     = ctrl_out.pc_write;
    assign IorD        = ctrl_out.iord;
    assign MemRead     = ctrl_out.mem_read;
    assign MemWrite    = ctrl_out.mem_write;
    assign MemToReg    = ctrl_out.mem_to_reg;
    assign IRWrite     = ctrl_out.ir_write;
    assign ALUControl  = ctrl_out.alu_control;
    assign trap        = ctrl_out.trap;
    assign state       = rst ? 4'd0 : state_q;
    assign illegal     = ~rst & (state_q == S_DECODE) & ~opcode_legal;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table of instructions with their
// state sequences, a reference model for the per-state outputs, and a scoreboard
// queue; two instances cover OVF_TRAP=1 and OVF_TRAP=0.
module tb_multicycle_control;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic        overflow;

    logic [1:0] pcs1, srcb1, pcs0, srcb0;
    logic [3:0] aluc1, st1, aluc0, st0;
    logic srca1, rw1, rdst1, pwc1, pw1, iord1, mr1, mw1, m2r1, irw1, ill1, trp1;
    logic srca0, rw0, rdst0, pwc0, pw0, iord0, mr0, mw0, m2r0, irw0, ill0, trp0;
    logic [23:0] act1, act0;

    typedef struct {
        logic [31:0] instr;
        logic        ovf;
        int          n;
        logic [19:0] seq;
        string       tag;
    } vec_t;

    typedef struct {
        logic [23:0] v1;
        logic [23:0] v0;
        string       tag;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks;
    int   errors;

    multicycle_control #(.OVF_TRAP(1'b1)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .overflow(overflow),
        .PCSource(pcs1), .ALUSrcB(srcb1), .ALUSrcA(srca1), .RegWrite(rw1),
        .RegDst(rdst1), .PCWriteCond(pwc1), .PCWrite(pw1), .IorD(iord1),
        .MemRead(mr1), .MemWrite(mw1), .MemToReg(m2r1), .IRWrite(irw1),
        .ALUControl(aluc1), .state(st1), .illegal(ill1), .trap(trp1)
    );

    multicycle_control #(.OVF_TRAP(1'b0)) dut_notrap (
        .clk(clk), .rst(rst), .instruction(instruction), .overflow(overflow),
        .PCSource(pcs0), .ALUSrcB(srcb0), .ALUSrcA(srca0), .RegWrite(rw0),
        .RegDst(rdst0), .PCWriteCond(pwc0), .PCWrite(pw0), .IorD(iord0),
        .MemRead(mr0), .MemWrite(mw0), .MemToReg(m2r0), .IRWrite(irw0),
        .ALUControl(aluc0), .state(st0), .illegal(ill0), .trap(trp0)
    );

    assign act1 = {pcs1, srcb1, srca1, rw1, rdst1, pwc1, pw1, iord1, mr1, mw1, m2r1, irw1, aluc1, st1, ill1, trp1};
    assign act0 = {pcs0, srcb0, srca0, rw0, rdst0, pwc0, pw0, iord0, mr0, mw0, m2r0, irw0, aluc0, st0, ill0, trp0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference outputs for one state: {PCSource, ALUSrcB, ALUSrcA, RegWrite, RegDst,
    // PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUControl, state, illegal, trap}
    function automatic logic [23:0] refModel(input logic [3:0] s, input logic [31:0] ir,
                                             input logic ovf, input logic trapen);
        logic [1:0] pcs, srcb;
        logic [3:0] aluc;
        logic srca, rw, rdst, pwc, pw, iord, mr, mw, m2r, irw, ill, trp, legal;
        logic [5:0] op, fn;
        op = ir[31:26];
        fn = ir[5:0];
        pcs = 2'b00; srcb = 2'b00; aluc = 4'b0010;
        srca = 0; rw = 0; rdst = 0; pwc = 0; pw = 0; iord = 0; mr = 0; mw = 0; m2r = 0; irw = 0; ill = 0; trp = 0;
        legal = (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h08) || (op == 6'h09) || (op == 6'h02) ||
                ((op == 6'h00) && (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A}));
        case (s)
            4'd0:  begin mr = 1; irw = 1; srcb = 2'b01; pw = 1; end
            4'd1:  begin srcb = 2'b11; ill = !legal; end
            4'd2:  begin srca = 1; srcb = 2'b10; end
            4'd3:  begin iord = 1; mr = 1; srca = 1; srcb = 2'b10; end
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin iord = 1; mw = 1; srca = 1; srcb = 2'b10; end
            4'd6: begin
                srca = 1;
                case (fn)
                    6'h22, 6'h23: aluc = 4'b0110;
                    6'h24:        aluc = 4'b0000;
                    6'h25:        aluc = 4'b0001;
                    6'h27:        aluc = 4'b1100;
                    6'h2A:        aluc = 4'b0111;
                    default:      aluc = 4'b0010;
                endcase
            end
            4'd7: begin
                rdst = 1;
                trp = ovf && trapen && (fn == 6'h20 || fn == 6'h22);
                rw = !trp;
            end
            4'd8:  begin srca = 1; aluc = 4'b0110; pwc = 1; pcs = 2'b01; end
            4'd9:  begin srca = 1; srcb = 2'b10; end
            4'd10: begin trp = ovf && trapen && (op == 6'h08); rw = !trp; end
            4'd11: begin pw = 1; pcs = 2'b11; end
            default: begin end
        endcase
        return {pcs, srcb, srca, rw, rdst, pwc, pw, iord, mr, mw, m2r, irw, aluc, s, ill, trp};
    endfunction

    function automatic vec_t mk(input logic [31:0] i, input logic o, input int n,
                                input logic [19:0] s, input string t);
        vec_t v;
        v.instr = i; v.ovf = o; v.n = n; v.seq = s; v.tag = t;
        return v;
    endfunction

    // Pop the oldest expectation and compare it against both instances.
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty: got no expectation, required one");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (act1 !== e.v1) begin
            errors++;
            $display("[TB] FAIL %s trap_on: got %h required %h (state %0d)", e.tag, act1, e.v1, e.v1[5:2]);
        end
        checks++;
        if (act0 !== e.v0) begin
            errors++;
            $display("[TB] FAIL %s trap_off: got %h required %h (state %0d)", e.tag, act0, e.v0, e.v0[5:2]);
        end
    endtask

    // Run one instruction from its FETCH cycle; leaves the bench 1 time unit after the next FETCH edge.
    task automatic applyStimulus(input vec_t v, input int stop_after);
        exp_t e;
        logic [19:0] sq;
        logic [3:0]  s;
        instruction = v.instr;
        overflow    = v.ovf;
        sq = v.seq;
        for (int k = 0; k < stop_after; k++) begin
            s = sq[4*k +: 4];
            e.v1 = refModel(s, v.instr, v.ovf, 1'b1);
            e.v0 = refModel(s, v.instr, v.ovf, 1'b0);
            e.tag = $sformatf("%s_c%0d", v.tag, k);
            sb.push_back(e);
            @(negedge clk);
            checkOutput();
            if (k != stop_after - 1) begin
                @(posedge clk);
                #1;
            end
        end
        if (stop_after == v.n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pushZero(input string t);
        exp_t e;
        e.v1 = '0;
        e.v0 = '0;
        e.tag = t;
        sb.push_back(e);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        instruction = 32'h8C820004;
        overflow = 1'b0;

        vecs.push_back(mk(32'h8C820004, 1'b0, 5, 20'h43210, "lw"));
        vecs.push_back(mk(32'hAC820008, 1'b0, 4, 20'h05210, "sw"));
        vecs.push_back(mk(32'h00622020, 1'b0, 4, 20'h07610, "add"));
        vecs.push_back(mk(32'h00622021, 1'b0, 4, 20'h07610, "addu"));
        vecs.push_back(mk(32'h00622022, 1'b0, 4, 20'h07610, "sub"));
        vecs.push_back(mk(32'h00622023, 1'b0, 4, 20'h07610, "subu"));
        vecs.push_back(mk(32'h00622024, 1'b0, 4, 20'h07610, "and"));
        vecs.push_back(mk(32'h00622025, 1'b0, 4, 20'h07610, "or"));
        vecs.push_back(mk(32'h00622027, 1'b0, 4, 20'h07610, "nor"));
        vecs.push_back(mk(32'h0062202A, 1'b0, 4, 20'h07610, "slt"));
        vecs.push_back(mk(32'h00622026, 1'b0, 2, 20'h00010, "funct26_illegal"));
        vecs.push_back(mk(32'h00622020, 1'b1, 4, 20'h07610, "add_ovf"));
        vecs.push_back(mk(32'h00622021, 1'b1, 4, 20'h07610, "addu_ovf"));
        vecs.push_back(mk(32'h00622022, 1'b1, 4, 20'h07610, "sub_ovf"));
        vecs.push_back(mk(32'h20420005, 1'b1, 4, 20'h0A910, "addi_ovf"));
        vecs.push_back(mk(32'h24420005, 1'b1, 4, 20'h0A910, "addiu_ovf"));
        vecs.push_back(mk(32'h20420005, 1'b0, 4, 20'h0A910, "addi"));
        vecs.push_back(mk(32'h10220003, 1'b0, 3, 20'h00810, "beq"));
        vecs.push_back(mk(32'h08000010, 1'b0, 3, 20'h00B10, "j"));
        vecs.push_back(mk(32'hFC000000, 1'b0, 2, 20'h00010, "opcode_illegal"));
        vecs.push_back(mk(32'h00622020, 1'b0, 4, 20'h07610, "add_after"));

        // Power-up reset: everything reads zero.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            pushZero($sformatf("reset_c%0d", c));
            @(negedge clk);
            checkOutput();
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) applyStimulus(vecs[i], vecs[i].n);

        // Reset asserted while a lw sits in MEMREAD, held three cycles.
        applyStimulus(vecs[0], 4);
        #1;
        rst = 1'b1;
        pushZero("midreset_memread");
        #1;
        checkOutput();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            pushZero($sformatf("midreset_hold_c%0d", c));
            @(negedge clk);
            checkOutput();
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(vecs[18], vecs[18].n);
        applyStimulus(vecs[0], vecs[0].n);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
